// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// loading, leading-zero blanking and per-digit blink.
module seg_scan_controller #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit_code,
  output logic [3:0]  an,
  output logic        dp,
  output logic        pending,
  output logic        frame_start
);

  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [BW-1:0]        BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [DIV_WIDTH-1:0] prescaler;
  logic [1:0]           scan_idx;
  logic [15:0]          display_reg;
  logic [15:0]          shadow;
  logic                 blink_phase;
  logic [BW-1:0]        blink_cnt;

  logic       tick;
  logic       frame_end;
  logic [3:0] cur_nibble;
  logic       upper_zero;
  logic       blanked;
  logic [3:0] an_sel;

  // Slot timing and blanking decision for the digit currently being scanned
  always_comb begin
    tick       = (prescaler == DIV_LAST);
    frame_end  = tick && (scan_idx == 2'd3);
    cur_nibble = 4'h0;
    upper_zero = 1'b0;
    case (scan_idx)
      2'd0: begin
        cur_nibble = display_reg[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        cur_nibble = display_reg[7:4];
        upper_zero = (display_reg[15:4] == 12'h000);
      end
      2'd2: begin
        cur_nibble = display_reg[11:8];
        upper_zero = (display_reg[15:8] == 8'h00);
      end
      default: begin
        cur_nibble = display_reg[15:12];
        upper_zero = (display_reg[15:12] == 4'h0);
      end
    endcase
    blanked = (blank_lz && upper_zero) || (blink_phase && blink_mask[scan_idx]);
    an_sel  = ~(4'b0001 << scan_idx);
  end

  // Scan counters, shadow/display registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      scan_idx    <= 2'd0;
      display_reg <= 16'h0000;
      shadow      <= 16'h0000;
      pending     <= 1'b0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
      digit_code  <= 4'h0;
      an          <= 4'b1111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick ? '0 : prescaler + DIV_WIDTH'(1);
      if (tick) begin
        scan_idx <= scan_idx + 2'd1;
      end
      frame_start <= frame_end;

      // Commit takes the old shadow; a same-edge load stays pending
      if (frame_end) begin
        if (pending) begin
          display_reg <= shadow;
        end
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end

      digit_code <= cur_nibble;
      an         <= blanked ? 4'b1111 : an_sel;
      dp         <= blanked ? 1'b1 : ~dp_in[scan_idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: cycle-count based reference
// model compared every cycle, plus directed literal checks.
module tb_seg_scan_controller;

  localparam int R  = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_in;
  logic [3:0]  digit_code;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_controller #(
    .REFRESH_DIV (R),
    .DIV_WIDTH   (16),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .dp_in      (dp_in),
    .digit_code (digit_code),
    .an         (an),
    .dp         (dp),
    .pending    (pending),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: position in the scan follows from the edge count since reset
  int          n;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend;
  logic        m_valid = 1'b0;
  logic [3:0]  e_code, e_an;
  logic        e_dp, e_pend, e_fs;

  always @(posedge clk) begin
    int idx;
    logic bnd, ph, blk;
    logic [15:0] up;
    m_valid = 1'b1;
    if (reset) begin
      n = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
      e_code = 4'h0; e_an = 4'b1111; e_dp = 1'b1; e_pend = 1'b0; e_fs = 1'b0;
    end else begin
      idx    = (n / R) % 4;
      bnd    = ((n % R) == R - 1) && (idx == 3);
      ph     = (((n / (4 * R)) / BF) % 2) != 0;
      up     = m_disp >> (4 * idx);
      e_code = up[3:0];
      blk    = (blank_lz && idx != 0 && up == 16'h0) || (ph && blink_mask[idx]);
      e_an   = blk ? 4'b1111 : ~(4'b0001 << idx);
      e_dp   = blk ? 1'b1 : ~dp_in[idx];
      e_fs   = bnd;
      if (bnd && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (load) begin
        m_shadow = value;
        m_pend   = 1'b1;
      end
      e_pend = m_pend;
      n++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_code", 16'(digit_code), 16'(e_code));
      cmp("model_an", 16'(an), 16'(e_an));
      cmp("model_dp", 16'(dp), 16'(e_dp));
      cmp("model_pending", 16'(pending), 16'(e_pend));
      cmp("model_frame_start", 16'(frame_start), 16'(e_fs));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fs();
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (frame_start !== 1'b1 && cnt < 100);
    if (frame_start !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_frame_start: got no pulse within %0d cycles, expected one", cnt);
    end
  endtask

  // Load at a frame start, then wait until the value is on display
  task automatic load_val(input logic [15:0] v);
    wait_fs();
    load = 1'b1; value = v;
    step(1);
    load = 1'b0;
    wait_fs();
  endtask

  initial begin
    int blanked_frames;
    reset = 1'b1; load = 1'b0; value = 16'h0;
    blank_lz = 1'b0; blink_mask = 4'b0; dp_in = 4'b0;

    step(3);
    cmp("reset_an", 16'(an), 16'h000F);
    cmp("reset_dp", 16'(dp), 16'h0001);
    cmp("reset_code", 16'(digit_code), 16'h0000);
    cmp("reset_pending", 16'(pending), 16'h0000);
    reset = 1'b0;

    step(1);
    cmp("scan_slot0_an", 16'(an), 16'h000E);
    step(4);
    cmp("scan_slot1_an", 16'(an), 16'h000D);

    // Mid-frame load is held in the shadow until the frame boundary
    load = 1'b1; value = 16'h1234;
    step(1);
    load = 1'b0;
    cmp("load_pending", 16'(pending), 16'h0001);
    cmp("load_still_old", 16'(digit_code), 16'h0000);
    wait_fs();
    cmp("commit_pending", 16'(pending), 16'h0000);
    step(1);
    cmp("d0_code", 16'(digit_code), 16'h0004);
    cmp("d0_an", 16'(an), 16'h000E);
    step(4);
    cmp("d1_code", 16'(digit_code), 16'h0003);
    step(4);
    cmp("d2_code", 16'(digit_code), 16'h0002);
    cmp("d2_an", 16'(an), 16'h000B);
    step(4);
    cmp("d3_code", 16'(digit_code), 16'h0001);
    cmp("d3_an", 16'(an), 16'h0007);

    // Leading-zero blanking
    blank_lz = 1'b1;
    load_val(16'h0042);
    step(1);
    cmp("lz_d0_code", 16'(digit_code), 16'h0002);
    cmp("lz_d0_an", 16'(an), 16'h000E);
    step(4);
    cmp("lz_d1_code", 16'(digit_code), 16'h0004);
    cmp("lz_d1_an", 16'(an), 16'h000D);
    step(4);
    cmp("lz_d2_an", 16'(an), 16'h000F);
    step(4);
    cmp("lz_d3_an", 16'(an), 16'h000F);
    load_val(16'h0000);
    step(1);
    cmp("lz0_d0_an", 16'(an), 16'h000E);
    cmp("lz0_d0_code", 16'(digit_code), 16'h0000);
    step(4);
    cmp("lz0_d1_an", 16'(an), 16'h000F);
    blank_lz = 1'b0;

    // Blink on digit 0: two of any four consecutive frames blanked
    load_val(16'h5678);
    blink_mask = 4'b0001;
    blanked_frames = 0;
    for (int f = 0; f < 4; f++) begin
      step(1);
      if (an == 4'b1111) blanked_frames++;
      step(4);
      cmp("blink_d1_an", 16'(an), 16'h000D);
      wait_fs();
    end
    cmp("blink_frames", 16'(blanked_frames), 16'h0002);
    blink_mask = 4'b0000;

    // Load landing on the exact boundary edge that commits an earlier load
    wait_fs();
    load = 1'b1; value = 16'h1111;
    step(1);
    load = 1'b0;
    step(4 * R - 2);
    load = 1'b1; value = 16'hAAAA;
    step(1);
    load = 1'b0;
    cmp("bnd_frame_start", 16'(frame_start), 16'h0001);
    cmp("bnd_pending", 16'(pending), 16'h0001);
    step(1);
    cmp("bnd_shows_1111", 16'(digit_code), 16'h0001);
    wait_fs();
    cmp("bnd_pending_clear", 16'(pending), 16'h0000);
    step(1);
    cmp("bnd_shows_aaaa", 16'(digit_code), 16'h000A);

    // Decimal point on digit 2 only
    dp_in = 4'b0100;
    wait_fs();
    step(1);
    cmp("dp_d0", 16'(dp), 16'h0001);
    step(8);
    cmp("dp_d2", 16'(dp), 16'h0000);
    step(4);
    cmp("dp_d3", 16'(dp), 16'h0001);
    dp_in = 4'b0000;

    // Reset mid-frame discards a pending load
    load = 1'b1; value = 16'hBEEF;
    step(1);
    load = 1'b0;
    reset = 1'b1;
    step(1);
    cmp("mid_rst_pending", 16'(pending), 16'h0000);
    cmp("mid_rst_an", 16'(an), 16'h000F);
    cmp("mid_rst_code", 16'(digit_code), 16'h0000);
    reset = 1'b0;
    step(1);
    cmp("post_rst_code", 16'(digit_code), 16'h0000);
    step(8 * R);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
